// File: rtl/div_recompose_mac.sv
// div_recompose_mac
//   Sequential shift-add multiply-accumulate that rebuilds a dividend from a
//   divider result: result = quotient * divisor + remainder.
//   Scans one divisor bit per clock (LSB first), then adds the remainder.
//   Optional feature macro: DIV_REMAINDER_CHECK_EN (adds rem_err output).
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   valid_in   : operands valid, sampled only while ready=1
//   quotient   : multiplicand, DIVIDEND_W bits
//   divisor    : multiplier, DIVISOR_W bits
//   remainder  : addend, DIVISOR_W bits
//   ready      : registered, high in IDLE only
//   result     : low DIVIDEND_W bits of quotient*divisor+remainder
//   overflow   : full sum does not fit in DIVIDEND_W bits
//   valid_out  : one-cycle pulse, result/overflow valid in that cycle
//   rem_err    : (macro only) remainder >= divisor or divisor == 0
module div_recompose_mac #(
  parameter int unsigned DIVISOR_W  = 16,
  parameter int unsigned DIVIDEND_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DIVIDEND_W-1:0] quotient,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic [DIVISOR_W-1:0]  remainder,
  output logic                  ready,
  output logic [DIVIDEND_W-1:0] result,
  output logic                  overflow,
  output logic                  valid_out
`ifdef DIV_REMAINDER_CHECK_EN
  ,
  output logic                  rem_err
`endif
);

  // Accumulator holds the max product plus the remainder carry.
  localparam int unsigned ACC_W = DIVIDEND_W + DIVISOR_W + 1;
  localparam int unsigned CNT_W = (DIVISOR_W > 1) ? $clog2(DIVISOR_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  valid_out_q, valid_out_d;
  logic [DIVIDEND_W-1:0] result_q, result_d;
  logic                  overflow_q, overflow_d;
`ifdef DIV_REMAINDER_CHECK_EN
  logic                  rem_err_q, rem_err_d;
`endif

  logic [ACC_W-1:0]      mul_term;
  logic [ACC_W-1:0]      sum_add;

  // Partial product for the current divisor bit and the final remainder sum.
  assign mul_term = ACC_W'(quot_q) << cnt_q;
  assign sum_add  = acc_q + ACC_W'(rem_q);

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      quot_q      <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_out_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
`ifdef DIV_REMAINDER_CHECK_EN
      rem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      valid_out_q <= valid_out_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
`ifdef DIV_REMAINDER_CHECK_EN
      rem_err_q   <= rem_err_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    quot_d      = quot_q;
    div_d       = div_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    valid_out_d = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
`ifdef DIV_REMAINDER_CHECK_EN
    rem_err_d   = rem_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          quot_d  = quotient;
          div_d   = divisor;
          rem_d   = remainder;
          acc_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (div_q[cnt_q]) begin
          acc_d = acc_q + mul_term;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d       = sum_add;
        result_d    = sum_add[DIVIDEND_W-1:0];
        overflow_d  = |sum_add[ACC_W-1:DIVIDEND_W];
`ifdef DIV_REMAINDER_CHECK_EN
        rem_err_d   = (rem_q >= div_q) || (div_q == '0);
`endif
        valid_out_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready     = ready_q;
  assign valid_out = valid_out_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
`ifdef DIV_REMAINDER_CHECK_EN
  assign rem_err   = rem_err_q;
`endif

endmodule
